recirculacion_param: RTL and testbench
======================================

Name: recirculacion_param

Overview:
- Parametrised successor of the 4-lane, 8-bit recirculation stage.
- Sits between the word source (probador or upstream stage) and the L1 stage.
- Each cycle, all NCH lanes go as one group either forward to L1 or back to the source (recirculation).
- The group is forwarded when a small FSM is ACTIVE and L1 is ready. Adds registered outputs, L1 backpressure, idle hysteresis and a saturating recirculated-word counter.

Parameters:
- NCH, 4: number of lanes.
- DW, 8: data width per lane.
- IDLE_HOLD, 2: consecutive IDL=1 cycles needed to leave ACTIVE (range 1..15).
- CW, 16: width of rec_count.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- IDL  in  1  upstream idle indication; 1 = idle.
- data_in  in  NCH*DW  lane k on bits [k*DW +: DW].
- valid_in  in  NCH  per-lane valid.
- l1_ready  in  1  L1 can accept a word group this cycle.
- count_clr  in  1  synchronous clear of rec_count.
- l1_data  out  NCH*DW  registered data to L1.
- l1_valid  out  NCH  registered valids to L1.
- rec_data  out  NCH*DW  registered data back to source.
- rec_valid  out  NCH  registered valids back to source.
- active  out  1  1 when FSM is in ACTIVE.
- rec_count  out  CW  total valid words recirculated, saturating.

Behaviour:
- All outputs and state are registered on clk. The only internal state is FSM state, hold counter, the output registers and rec_count.
- Reset (reset=1 at a clk edge), taking priority over everything including count_clr:
  - state=IDLE, hold counter=0.
  - l1_data=0, l1_valid=0, rec_data=0, rec_valid=0.
  - rec_count=0, active=0.
  - Reset mid-traffic discards the in-flight group; no output is held.
- FSM states: IDLE, ACTIVE.
  - IDLE -> ACTIVE when IDL=0 is sampled. Hold counter cleared.
  - ACTIVE, IDL=0: hold counter cleared, stay ACTIVE.
  - ACTIVE, IDL=1: hold counter increments. When the incremented value reaches IDLE_HOLD, go to IDLE and clear the hold counter.
  - IDLE_HOLD=1 means a single IDL=1 cycle leaves ACTIVE.
- Routing decision uses the current (pre-edge) state: fwd = (state==ACTIVE) && l1_ready.
  - An IDL change therefore affects routing from the second edge after it is applied.
- Datapath, latency 1 cycle (inputs at edge n appear on outputs after edge n):
  - fwd=1: l1_valid<=valid_in; l1_data lane k <= valid_in[k] ? data_in lane k : 0; rec_valid<=0; rec_data<=0.
  - fwd=0: rec_valid<=valid_in; rec_data lane k masked the same way; l1_valid<=0; l1_data<=0.
  - Invalid lanes always output zero data on both paths.
  - Routing is all-or-nothing per cycle; lanes are never split between L1 and recirculation.
  - Every input word appears on exactly one output path. None is dropped or duplicated. The exception is words sampled during reset, which are discarded.
- rec_count:
  - On fwd=0 cycles: rec_count <= min(rec_count + popcount(valid_in), 2^CW-1).
  - Popcount width is clog2(NCH+1). The addition is done in CW+1 bits before saturating.
  - count_clr=1 sets rec_count to 0 on the same edge, overriding that cycle's increment.
  - No change on fwd=1 cycles or when valid_in=0.
- active = (state==ACTIVE), registered alongside the state.
- l1_ready is sampled only in ACTIVE. A drop of l1_ready recirculates that cycle's group with no state change.

Test Plan:
- Reset: apply data_in=all 0xFF, valid_in=4'hF, IDL=0 with reset=1 for 2 cycles. -> All outputs are 0 and active=0 during reset. On the first edge after release, the group goes to rec_valid=4'hF because the state was still IDLE; active=1.
- Forward: ACTIVE, l1_ready=1, lanes 0..3 = 0x11,0x22,0x33,0x44, valid_in=4'b1011. -> Next cycle: l1_data lanes = 0x11,0x22,0x00,0x44; l1_valid=4'b1011; rec_valid=0; rec_count unchanged.
- Backpressure: ACTIVE, l1_ready=0 for 3 cycles, valid_in=4'hF each cycle. -> Groups appear on rec_*; rec_count goes 0→4→8→12; state stays ACTIVE.
- Hysteresis (IDLE_HOLD=2): ACTIVE, IDL pattern 1,0,1,1. -> active stays 1 after the first 1 because the hold counter is reset by the 0. active drops to 0 after the second consecutive 1. The following group goes to rec_*.
- Saturation and clear (CW=4): recirculate 4 full groups. -> rec_count=15, not 16 or wrap to 0. Then count_clr=1 together with a valid recirculated group. -> rec_count=0.
- Mid-operation reset: reset=1 for 1 cycle while ACTIVE with traffic. -> Outputs are 0 next cycle, state=IDLE, no word appears on l1_*.

Source files
------------

// File: rtl/recirculacion_param.sv
`default_nettype none
// ============================================================================
//  Module      : recirculacion_param
//  Description : NCH-lane recirculation stage; each cycle the whole word group
//                goes either to L1 or back to the source, all outputs registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module recirculacion_param #(
    parameter int NCH       = 4,
    parameter int DW        = 8,
    parameter int IDLE_HOLD = 2,
    parameter int CW        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              IDL,
    input  logic [NCH*DW-1:0] data_in,
    input  logic [NCH-1:0]    valid_in,
    input  logic              l1_ready,
    input  logic              count_clr,
    output logic [NCH*DW-1:0] l1_data,
    output logic [NCH-1:0]    l1_valid,
    output logic [NCH*DW-1:0] rec_data,
    output logic [NCH-1:0]    rec_valid,
    output logic              active,
    output logic [CW-1:0]     rec_count
);

    localparam int         c_PCW      = $clog2(NCH + 1);
    localparam int         c_SW       = CW + 1;
    localparam logic [3:0] c_HOLD_LIM = 4'(IDLE_HOLD);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [3:0]          r_hold, w_hold_nxt;
    logic                r_active;
    logic [NCH*DW-1:0]   r_l1_data, r_rec_data, w_masked;
    logic [NCH-1:0]      r_l1_valid, r_rec_valid;
    logic [CW-1:0]       r_rec_count, w_cnt_nxt;
    logic [c_PCW-1:0]    w_pop;
    logic [c_SW-1:0]     w_sum;
    logic                w_fwd;

    // Idle hysteresis: only IDLE_HOLD consecutive idle cycles leave ACTIVE
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = '0;
        case (r_state)
            S_IDLE: begin
                if (!IDL) w_state_nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (IDL) begin
                    if (r_hold + 4'd1 == c_HOLD_LIM) w_state_nxt = S_IDLE;
                    else                             w_hold_nxt  = r_hold + 4'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_fwd = (r_state == S_ACTIVE) && l1_ready;

    generate
        for (genvar k = 0; k < NCH; k++) begin : g_lane
            assign w_masked[k*DW +: DW] = valid_in[k] ? data_in[k*DW +: DW] : '0;
        end
    endgenerate

    always_comb begin
        w_pop = '0;
        for (int k = 0; k < NCH; k++) begin
            w_pop = w_pop + c_PCW'(valid_in[k]);
        end
    end

    // Sum carries one extra bit so overflow is visible for saturation
    assign w_sum     = {1'b0, r_rec_count} + c_SW'(w_pop);
    assign w_cnt_nxt = w_sum[CW] ? '1 : w_sum[CW-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_hold      <= '0;
            r_active    <= 1'b0;
            r_l1_data   <= '0;
            r_l1_valid  <= '0;
            r_rec_data  <= '0;
            r_rec_valid <= '0;
            r_rec_count <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_hold   <= w_hold_nxt;
            r_active <= (w_state_nxt == S_ACTIVE);
            if (w_fwd) begin
                r_l1_data   <= w_masked;
                r_l1_valid  <= valid_in;
                r_rec_data  <= '0;
                r_rec_valid <= '0;
            end else begin
                r_l1_data   <= '0;
                r_l1_valid  <= '0;
                r_rec_data  <= w_masked;
                r_rec_valid <= valid_in;
            end
            if (count_clr)   r_rec_count <= '0;
            else if (!w_fwd) r_rec_count <= w_cnt_nxt;
        end
    end

    assign l1_data   = r_l1_data;
    assign l1_valid  = r_l1_valid;
    assign rec_data  = r_rec_data;
    assign rec_valid = r_rec_valid;
    assign active    = r_active;
    assign rec_count = r_rec_count;

endmodule
`default_nettype wire

// File: tb/tb_recirculacion_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_recirculacion_param
//  Description : Self-checking bench for recirculacion_param against a
//                behavioural routing/count model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_recirculacion_param;

    localparam int NCH       = 4;
    localparam int DW        = 8;
    localparam int IDLE_HOLD = 2;
    localparam int CW        = 4;
    localparam int c_MAXCNT  = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              reset, IDL, l1_ready, count_clr;
    logic [NCH*DW-1:0] data_in;
    logic [NCH-1:0]    valid_in;
    logic [NCH*DW-1:0] l1_data, rec_data;
    logic [NCH-1:0]    l1_valid, rec_valid;
    logic              active;
    logic [CW-1:0]     rec_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit                m_act  = 1'b0;
    int                m_hold = 0;
    int                m_cnt  = 0;
    logic [NCH*DW-1:0] m_l1d  = '0, m_recd = '0;
    logic [NCH-1:0]    m_l1v  = '0, m_recv = '0;

    always #5 clk = ~clk;

    recirculacion_param #(
        .NCH(NCH), .DW(DW), .IDLE_HOLD(IDLE_HOLD), .CW(CW)
    ) dut (
        .clk(clk), .reset(reset), .IDL(IDL), .data_in(data_in),
        .valid_in(valid_in), .l1_ready(l1_ready), .count_clr(count_clr),
        .l1_data(l1_data), .l1_valid(l1_valid), .rec_data(rec_data),
        .rec_valid(rec_valid), .active(active), .rec_count(rec_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model, then compare every output
    task automatic step(input logic rst_i, input logic idl_i,
                        input logic [NCH*DW-1:0] d, input logic [NCH-1:0] v,
                        input logic rdy, input logic clr);
        logic [NCH*DW-1:0] masked;
        bit                fwd;
        reset = rst_i; IDL = idl_i; data_in = d; valid_in = v;
        l1_ready = rdy; count_clr = clr;
        @(posedge clk);
        masked = '0;
        for (int k = 0; k < NCH; k++)
            if (v[k]) masked[k*DW +: DW] = d[k*DW +: DW];
        if (rst_i) begin
            m_act = 1'b0; m_hold = 0; m_cnt = 0;
            m_l1d = '0; m_l1v = '0; m_recd = '0; m_recv = '0;
        end else begin
            fwd = m_act && rdy;
            m_l1d  = fwd ? masked : '0;
            m_l1v  = fwd ? v : '0;
            m_recd = fwd ? '0 : masked;
            m_recv = fwd ? '0 : v;
            if (clr) m_cnt = 0;
            else if (!fwd) begin
                m_cnt = m_cnt + $countones(v);
                if (m_cnt > c_MAXCNT) m_cnt = c_MAXCNT;
            end
            if (!m_act) begin
                m_hold = 0;
                m_act  = !idl_i;
            end else if (!idl_i) begin
                m_hold = 0;
            end else begin
                m_hold++;
                if (m_hold == IDLE_HOLD) begin
                    m_act  = 1'b0;
                    m_hold = 0;
                end
            end
        end
        #1;
        chk("l1_data",   l1_data,   m_l1d);
        chk("l1_valid",  l1_valid,  m_l1v);
        chk("rec_data",  rec_data,  m_recd);
        chk("rec_valid", rec_valid, m_recv);
        chk("active",    active,    m_act);
        chk("rec_count", rec_count, m_cnt[CW-1:0]);
    endtask

    initial begin
        logic [NCH*DW-1:0] rd;

        // Reset held for two cycles with traffic present
        step(1, 0, '1, 4'hF, 1, 0);
        chk("rst_l1v", l1_valid, 4'h0);
        chk("rst_act", active, 1'b0);
        step(1, 0, '1, 4'hF, 1, 0);
        step(0, 0, '1, 4'hF, 1, 0);
        chk("rel_recv", rec_valid, 4'hF);
        chk("rel_act", active, 1'b1);

        // Forward with a masked lane
        step(0, 0, 32'h44332211, 4'b1011, 1, 0);
        chk("fwd_l1d", l1_data, 32'h44002211);
        chk("fwd_l1v", l1_valid, 4'b1011);
        chk("fwd_cnt", rec_count, 4'd4);

        // Backpressure
        step(0, 0, '0, 4'h0, 1, 1);
        step(0, 0, 32'hA1A2A3A4, 4'hF, 0, 0);
        chk("bp_cnt4", rec_count, 4'd4);
        step(0, 0, 32'hB1B2B3B4, 4'hF, 0, 0);
        chk("bp_cnt8", rec_count, 4'd8);
        step(0, 0, 32'hC1C2C3C4, 4'hF, 0, 0);
        chk("bp_cnt12", rec_count, 4'd12);
        chk("bp_act", active, 1'b1);

        // Hysteresis: IDL = 1,0,1,1
        step(0, 1, 32'h01020304, 4'hF, 1, 1);
        chk("hys_act1", active, 1'b1);
        step(0, 0, 32'h05060708, 4'hF, 1, 0);
        step(0, 1, 32'h090A0B0C, 4'hF, 1, 0);
        chk("hys_act3", active, 1'b1);
        step(0, 1, 32'h0D0E0F10, 4'hF, 1, 0);
        chk("hys_drop", active, 1'b0);
        chk("hys_l1v", l1_valid, 4'hF);
        step(0, 1, 32'h11121314, 4'hF, 1, 0);
        chk("hys_recv", rec_valid, 4'hF);

        // Saturation then clear
        step(0, 1, '0, 4'h0, 1, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 32'hDEADBEEF, 4'hF, 1, 0);
        chk("sat_cnt", rec_count, 4'd15);
        step(0, 1, 32'hDEADBEEF, 4'hF, 1, 1);
        chk("clr_cnt", rec_count, 4'd0);

        // Mid-operation reset
        step(0, 0, '0, 4'h0, 1, 0);
        step(0, 0, 32'h12345678, 4'hF, 1, 0);
        chk("pre_l1v", l1_valid, 4'hF);
        step(1, 0, 32'h9ABCDEF0, 4'hF, 1, 0);
        chk("mr_l1v", l1_valid, 4'h0);
        chk("mr_act", active, 1'b0);
        step(0, 0, 32'h0F0F0F0F, 4'hF, 1, 0);
        chk("mr_after_l1v", l1_valid, 4'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rd = {$urandom, $urandom};
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0), rd,
                 NCH'($urandom), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 15) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
